shift_add_mult_16: RTL and testbench

Sequential 16x16 unsigned multiplier built around one rca_16 instance as its only adder. One shift-and-add iteration per clock. This block is the consumer of rca_16's sum/c_out and the next stage above it in the DE2 arithmetic path. Start/busy/done handshake; result held in a register until the next completion.

---
 rtl/shift_add_mult_16.sv | 120 ++++++++++++
 tb/tb_shift_add_mult_16.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mult_16.sv
// Sequential 16x16 unsigned shift-and-add multiplier, one iteration per clock.
// The only adder is rca_16, a ripple-carry chain of per-bit full_adder cells.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module rca_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] sum,
    output logic        c_out
);
    logic [16:0] c;

    assign c[0]  = c_in;
    assign c_out = c[16];

    for (genvar i = 0; i < 16; i++) begin : g_bit
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end
endmodule

module shift_add_mult_16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] mcand;
    logic [31:0] acc;
    logic [3:0]  cnt;

    logic [15:0] add_b;
    logic [15:0] sum;
    logic        c_out;
    logic [31:0] acc_nxt;

    // Low half of acc holds the remaining multiplier bits; its LSB gates the add.
    assign add_b   = acc[0] ? mcand : 16'h0000;
    // The carry becomes bit 31 before the shift, so the result never overflows.
    assign acc_nxt = {c_out, sum, acc[15:1]};

    rca_16 u_rca (
        .a     (acc[31:16]),
        .b     (add_b),
        .c_in  (1'b0),
        .sum   (sum),
        .c_out (c_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= 32'h0;
            mcand   <= 16'h0;
            acc     <= 32'h0;
            cnt     <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand <= a;
                        acc   <= {16'h0000, b};
                        cnt   <= 4'd0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        product <= acc_nxt;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shift_add_mult_16.sv
// Scoreboard bench for shift_add_mult_16: stimulus pushes expected products,
// a negedge monitor pops them on each done pulse and checks timing/holding.

module tb_shift_add_mult_16;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] held = 32'h0;
    int          run_len = 0;
    logic        prev_busy = 1'b0;
    logic        prev_done = 1'b0;
    int          cyc = 0;
    int          last_done_cyc = 0;
    int          done_cnt = 0;
    bit          chk_spacing = 1'b0;

    shift_add_mult_16 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            run_len   = 0;
            prev_busy = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (busy) begin
                run_len++;
            end else if (prev_busy) begin
                check("busy_len", 32'(run_len), 32'd16);
                run_len = 0;
            end
            if (done) begin
                check("done_after_run", {31'h0, prev_busy}, 32'd1);
                check("done_width", {31'h0, prev_done}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got product %08h expected no done", product);
                end else begin
                    held = exp_q.pop_front();
                    check("product", product, held);
                end
                if (chk_spacing && last_done_cyc > 0)
                    check("done_spacing", 32'(cyc - last_done_cyc), 32'd18);
                last_done_cyc = cyc;
                done_cnt++;
            end else begin
                check("product_hold", product, held);
            end
            prev_busy = busy;
            prev_done = done;
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy && !done) return;
        end
        checks++;
        errors++;
        $display("FAIL idle_timeout: got busy=%0b done=%0b expected idle", busy, done);
    endtask

    task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic [31:0] exp);
        wait_idle();
        start = 1'b1;
        a     = ia;
        b     = ib;
        exp_q.push_back(exp);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    initial begin
        int target;
        rst_n = 1'b0;
        start = 1'b0;
        a     = 16'h0;
        b     = 16'h0;
        #1;
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_done", {31'h0, done}, 32'd0);
        check("rst_product", product, 32'h0);
        #12 rst_n = 1'b1;

        issue(16'd3, 16'd5, 32'h0000000F);
        check("busy_after_start", {31'h0, busy}, 32'd1);
        issue(16'hFFFF, 16'hFFFF, 32'hFFFE0001);
        issue(16'h8000, 16'h0002, 32'h00010000);
        issue(16'h1234, 16'h0000, 32'h00000000);
        issue(16'h0000, 16'hBEEF, 32'h00000000);

        // start pulse mid-run and operand changes must not disturb the operation
        issue(16'd7, 16'd9, 32'h0000003F);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        a     = 16'd1;
        b     = 16'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 16'hAAAA;
        b     = 16'h5555;
        wait_idle();
        repeat (20) @(posedge clk);
        #1;
        check("no_extra_busy", {31'h0, busy}, 32'd0);
        check("no_extra_pending", 32'(exp_q.size()), 32'd0);

        // asynchronous reset in the middle of a run
        issue(16'hFFFF, 16'hFFFF, 32'hFFFE0001);
        repeat (8) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_busy", {31'h0, busy}, 32'd0);
        check("async_rst_done", {31'h0, done}, 32'd0);
        check("async_rst_product", product, 32'h0);
        exp_q.delete();
        held = 32'h0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        issue(16'd2, 16'd3, 32'h00000006);

        // start held high: back-to-back operations every 18 edges
        wait_idle();
        chk_spacing   = 1'b1;
        last_done_cyc = 0;
        target        = done_cnt + 3;
        start         = 1'b1;
        a             = 16'd2;
        b             = 16'd2;
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h4);
        begin : hold_wait
            for (int i = 0; i < 120; i++) begin
                @(posedge clk);
                if (done_cnt >= target) disable hold_wait;
            end
            checks++;
            errors++;
            $display("FAIL hold_timeout: got %0d dones expected %0d", done_cnt, target);
        end
        #1 start = 1'b0;
        chk_spacing = 1'b0;

        wait_idle();
        repeat (3) @(negedge clk);
        check("final_pending", 32'(exp_q.size()), 32'd0);
        check("final_busy", {31'h0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
